// File: rtl/time_knob_decoder.sv
// Rotary encoder front end for the delay-time control: synchronises and debounces A/B/SW,
// decodes detented quadrature into a saturating 4-bit position and its Gray-coded time select.
module time_knob_decoder #(
  parameter int          DEB_CYCLES    = 50000,
  parameter int          STEPS_PER_DET = 4,
  parameter logic [3:0]  POS_RESET     = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_sw,
  output logic [3:0] pos,
  output logic [3:0] time_gray,
  output logic       changed
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic signed [3:0] SUB_MAX = 4'(STEPS_PER_DET - 1);
  localparam logic signed [3:0] SUB_MIN = -SUB_MAX;

  // State encoding follows the CW order so a +1 index difference is a CW transition.
  typedef enum logic [1:0] {
    Q11 = 2'd0,
    Q10 = 2'd1,
    Q00 = 2'd2,
    Q01 = 2'd3
  } q_state_t;

  logic [2:0]        pins;
  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic [2:0]        deb;
  logic [CW-1:0]     cnt [3];
  logic              sw_prev;
  logic              press;
  q_state_t          state;
  q_state_t          state_next;
  q_state_t          cur;
  logic [1:0]        diff;
  logic signed [3:0] sub;
  logic signed [3:0] sub_next;
  logic              step_up;
  logic              step_dn;
  logic [3:0]        pos_next;
  logic              changed_next;

  function automatic q_state_t to_state(input logic [1:0] ab);
    case (ab)
      2'b11:   return Q11;
      2'b10:   return Q10;
      2'b00:   return Q00;
      default: return Q01;
    endcase
  endfunction

  function automatic logic [3:0] gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  assign pins  = {enc_a, enc_b, enc_sw};
  assign press = sw_prev & ~deb[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '1;
      sync2   <= '1;
      deb     <= '1;
      sw_prev <= 1'b1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1   <= pins;
      sync2   <= sync1;
      sw_prev <= deb[0];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= Q11;
      sub       <= '0;
      pos       <= POS_RESET;
      time_gray <= gray(POS_RESET);
      changed   <= 1'b0;
    end else begin
      state     <= state_next;
      sub       <= sub_next;
      pos       <= pos_next;
      time_gray <= gray(pos_next);
      changed   <= changed_next;
    end
  end

  // The state always follows the debounced pair; only the sub-count cares whether the move was legal.
  always_comb begin
    cur          = to_state({deb[2], deb[1]});
    diff         = 2'(cur) - 2'(state);
    state_next   = cur;
    sub_next     = sub;
    step_up      = 1'b0;
    step_dn      = 1'b0;
    pos_next     = pos;
    changed_next = 1'b0;

    case (diff)
      2'd1: begin
        if (sub == SUB_MAX) begin
          step_up  = 1'b1;
          sub_next = '0;
        end else begin
          sub_next = sub + 4'sd1;
        end
      end
      2'd3: begin
        if (sub == SUB_MIN) begin
          step_dn  = 1'b1;
          sub_next = '0;
        end else begin
          sub_next = sub - 4'sd1;
        end
      end
      2'd2:    sub_next = '0;
      default: ;
    endcase

    if (press) begin
      sub_next     = '0;
      pos_next     = POS_RESET;
      changed_next = (pos != POS_RESET);
    end else if (step_up && pos != 4'd15) begin
      pos_next     = pos + 4'd1;
      changed_next = 1'b1;
    end else if (step_dn && pos != 4'd0) begin
      pos_next     = pos - 4'd1;
      changed_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_time_knob_decoder.sv
// Scoreboard bench for time_knob_decoder: two instances (reset position 0 and 8) share one
// encoder stimulus; each expected position change is queued and matched against changed pulses.
module tb_time_knob_decoder;

  localparam int DEB   = 4;
  localparam int STEPS = 4;
  localparam int HOLD  = 10;
  localparam int RST0  = 0;
  localparam int RST8  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enc_a;
  logic       enc_b;
  logic       enc_sw;
  logic [3:0] pos0, gray0, pos8, gray8;
  logic       chg0, chg8;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         mpos0, mpos8, msub, exp_mid;
  logic [1:0] mab;
  logic       msw;
  int         exp_q0[$];
  int         exp_q8[$];

  always #5 clk = ~clk;

  time_knob_decoder #(.DEB_CYCLES(DEB), .STEPS_PER_DET(STEPS), .POS_RESET(4'd0)) dut0 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .pos(pos0), .time_gray(gray0), .changed(chg0)
  );

  time_knob_decoder #(.DEB_CYCLES(DEB), .STEPS_PER_DET(STEPS), .POS_RESET(4'd8)) dut8 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .pos(pos8), .time_gray(gray8), .changed(chg8)
  );

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int cw_idx(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check_output(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one debounced input change, applied to both instances.
  task automatic model_update(input logic [1:0] ab, input logic sw);
    int   d;
    int   step;
    logic pr;
    pr   = msw && !sw;
    step = 0;
    if (ab != mab) begin
      d = (cw_idx(ab) - cw_idx(mab)) & 3;
      if (d == 1) begin
        if (msub == STEPS - 1) begin step = 1; msub = 0; end
        else msub++;
      end else if (d == 3) begin
        if (msub == -(STEPS - 1)) begin step = -1; msub = 0; end
        else msub--;
      end else begin
        msub = 0;
      end
    end
    mab = ab;
    msw = sw;
    if (pr) begin
      msub = 0;
      if (mpos0 != RST0) exp_q0.push_back(RST0);
      if (mpos8 != RST8) exp_q8.push_back(RST8);
      mpos0 = RST0;
      mpos8 = RST8;
    end else if (step != 0) begin
      if (mpos0 + step >= 0 && mpos0 + step <= 15) begin
        mpos0 += step;
        exp_q0.push_back(mpos0);
      end
      if (mpos8 + step >= 0 && mpos8 + step <= 15) begin
        mpos8 += step;
        exp_q8.push_back(mpos8);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] ab, input logic sw, input int hold);
    enc_a  = ab[1];
    enc_b  = ab[0];
    enc_sw = sw;
    model_update(ab, sw);
    wait_cycles(hold);
  endtask

  task automatic detent(input bit cw, input int n);
    for (int k = 0; k < n; k++) begin
      if (cw) begin
        apply_stimulus(2'b10, msw, HOLD);
        apply_stimulus(2'b00, msw, HOLD);
        apply_stimulus(2'b01, msw, HOLD);
      end else begin
        apply_stimulus(2'b01, msw, HOLD);
        apply_stimulus(2'b00, msw, HOLD);
        apply_stimulus(2'b10, msw, HOLD);
      end
      apply_stimulus(2'b11, msw, HOLD);
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, "_pos0"}, int'(pos0), mpos0);
    check_output({tag, "_gray0"}, int'(gray0), gray_of(mpos0));
    check_output({tag, "_pos8"}, int'(pos8), mpos8);
    check_output({tag, "_gray8"}, int'(gray8), gray_of(mpos8));
    check_output({tag, "_sub"}, int'(dut0.sub), msub);
    check_output({tag, "_q0_left"}, exp_q0.size(), 0);
    check_output({tag, "_q8_left"}, exp_q8.size(), 0);
  endtask

  // Every changed pulse must match the oldest queued expectation for that instance.
  always @(negedge clk) begin
    int e;
    if (chg0) begin
      if (exp_q0.size() == 0) check_output("chg0_spurious", int'(chg0), 0);
      else begin
        e = exp_q0.pop_front();
        check_output("chg0_pos", int'(pos0), e);
        check_output("chg0_gray", int'(gray0), gray_of(e));
      end
    end
    if (chg8) begin
      if (exp_q8.size() == 0) check_output("chg8_spurious", int'(chg8), 0);
      else begin
        e = exp_q8.pop_front();
        check_output("chg8_pos", int'(pos8), e);
        check_output("chg8_gray", int'(gray8), gray_of(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    enc_a  = 1'b1;
    enc_b  = 1'b1;
    enc_sw = 1'b1;
    mpos0  = RST0;
    mpos8  = RST8;
    msub   = 0;
    mab    = 2'b11;
    msw    = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    check_state("reset");
    wait_cycles(100);
    check_state("idle");

    apply_stimulus(2'b10, 1'b1, HOLD);
    apply_stimulus(2'b00, 1'b1, HOLD);
    apply_stimulus(2'b01, 1'b1, HOLD);
    enc_a = 1'b1;
    enc_b = 1'b1;
    model_update(2'b11, 1'b1);
    wait_cycles(6);
    check_output("lat_early", int'(chg0), 0);
    wait_cycles(1);
    check_output("lat_pulse", int'(chg0), 1);
    wait_cycles(1);
    check_output("lat_after", int'(chg0), 0);
    wait_cycles(HOLD - 8);
    check_state("cw1");

    detent(1'b1, 14);
    check_state("cw15");
    detent(1'b1, 3);
    check_state("sat15");
    detent(1'b0, 1);
    check_state("ccw14");

    enc_a = 1'b0;
    wait_cycles(DEB - 1);
    enc_a = 1'b1;
    for (int k = 0; k < HOLD; k++) begin
      wait_cycles(1);
      check_output("glitch_sub", int'(dut0.sub), msub);
    end
    check_state("glitch");

    enc_a = 1'b0;
    model_update(2'b01, 1'b1);
    exp_mid = msub;
    wait_cycles(DEB + 1);
    enc_a = 1'b1;
    model_update(2'b11, 1'b1);
    wait_cycles(4);
    check_output("pulse_a_mid", int'(dut0.sub), exp_mid);
    wait_cycles(HOLD);
    check_state("pulse_a");

    enc_b = 1'b0;
    model_update(2'b10, 1'b1);
    exp_mid = msub;
    wait_cycles(DEB + 1);
    enc_b = 1'b1;
    model_update(2'b11, 1'b1);
    wait_cycles(4);
    check_output("pulse_b_mid", int'(dut0.sub), exp_mid);
    wait_cycles(HOLD);
    check_state("pulse_b");

    apply_stimulus(2'b10, 1'b1, HOLD);
    check_output("half_sub1", int'(dut0.sub), msub);
    apply_stimulus(2'b00, 1'b1, HOLD);
    check_output("half_sub2", int'(dut0.sub), msub);
    apply_stimulus(2'b10, 1'b1, HOLD);
    check_output("half_sub3", int'(dut0.sub), msub);
    apply_stimulus(2'b11, 1'b1, HOLD);
    check_state("half");

    apply_stimulus(2'b10, 1'b1, HOLD);
    apply_stimulus(2'b01, 1'b1, HOLD);
    check_output("inv_sub1", int'(dut0.sub), msub);
    apply_stimulus(2'b11, 1'b1, HOLD);
    check_output("inv_sub2", int'(dut0.sub), msub);
    apply_stimulus(2'b00, 1'b1, HOLD);
    check_output("inv_sub3", int'(dut0.sub), msub);
    apply_stimulus(2'b11, 1'b1, HOLD);
    check_state("invalid");

    apply_stimulus(2'b11, 1'b0, HOLD);
    check_state("press");
    apply_stimulus(2'b11, 1'b1, HOLD);
    check_state("release");
    detent(1'b0, 5);
    check_state("ccw_sat0");

    apply_stimulus(2'b10, 1'b1, HOLD);
    apply_stimulus(2'b00, 1'b1, HOLD);
    apply_stimulus(2'b01, 1'b1, HOLD);
    apply_stimulus(2'b11, 1'b0, HOLD);
    check_state("press_step");
    detent(1'b1, 1);
    check_state("held");
    apply_stimulus(2'b11, 1'b1, HOLD);
    check_state("release2");

    apply_stimulus(2'b10, 1'b1, HOLD);
    apply_stimulus(2'b00, 1'b1, HOLD);
    check_output("pre_rst_sub", int'(dut8.sub), msub);
    rst = 1'b1;
    wait_cycles(3);
    rst   = 1'b0;
    mpos0 = RST0;
    mpos8 = RST8;
    msub  = 0;
    mab   = 2'b11;
    msw   = 1'b1;
    check_state("mid_rst");
    model_update(2'b00, 1'b1);
    wait_cycles(HOLD);
    check_state("post_rst");
    apply_stimulus(2'b11, 1'b1, HOLD);
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
